// File: rtl/lpf_interp.sv
// lpf_interp: upsample-by-N linear interpolator for signed sample streams.
// Each accepted low-rate sample produces N output beats that ramp from the
// previous sample to the new one; the final beat equals the new sample.
module lpf_interp #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] y_out
);

  localparam int N     = 1 << LOG2_N;
  localparam int ACC_W = DATA_W + LOG2_N + 1;
  localparam int DLT_W = DATA_W + 1;
  localparam int K_W   = LOG2_N + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [DATA_W-1:0]  r_x_prev;
  logic signed [DATA_W-1:0]  r_x_cur;
  logic signed [DLT_W-1:0]   r_delta;
  logic signed [ACC_W-1:0]   r_acc;
  logic        [K_W-1:0]     r_k;
  logic signed [DATA_W-1:0]  r_y;

  logic                      w_last;
  logic                      w_xfer;
  logic                      w_accept;
  logic signed [DATA_W-1:0]  w_base;
  logic signed [DLT_W-1:0]   w_delta;
  logic signed [ACC_W-1:0]   w_acc_start;
  logic signed [ACC_W-1:0]   w_acc_step;

  // Arithmetic shift floors toward -inf; the beat always lies between the two
  // end samples, so truncating to DATA_W never overflows and needs no clamp.
  function automatic logic signed [DATA_W-1:0] f_beat(input logic signed [ACC_W-1:0] acc);
    return DATA_W'(acc >>> LOG2_N);
  endfunction

  assign out_valid = (r_state == S_RUN);
  assign y_out     = r_y;
  assign w_last    = (r_k == K_W'(N));
  assign w_xfer    = out_valid && out_ready;
  // out_ready feeds in_ready combinationally so a new ramp follows the last
  // beat of the previous one without a bubble.
  assign in_ready  = (r_state == S_IDLE) || (out_ready && w_last);
  assign w_accept  = in_valid && in_ready;

  // When accepting on the final beat, x_prev has not been updated yet, so the
  // new ramp must start from x_cur, which is the sample just completed.
  assign w_base      = (r_state == S_RUN) ? r_x_cur : r_x_prev;
  assign w_delta     = {x_in[DATA_W-1], x_in} - {w_base[DATA_W-1], w_base};
  assign w_acc_start = (ACC_W'(w_base) <<< LOG2_N) + ACC_W'(w_delta);
  assign w_acc_step  = r_acc + ACC_W'(r_delta);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: enter RUN on accept, return to IDLE after the last beat
  // leaves unless another sample is taken in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_RUN;
      S_RUN:  if (w_xfer && w_last && !w_accept) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ramp datapath: load on accept, step on each beat transfer, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_prev <= '0;
      r_x_cur  <= '0;
      r_delta  <= '0;
      r_acc    <= '0;
      r_k      <= '0;
      r_y      <= '0;
    end else if (w_accept) begin
      r_acc   <= w_acc_start;
      r_y     <= f_beat(w_acc_start);
      r_k     <= K_W'(1);
      r_x_cur <= x_in;
      r_delta <= w_delta;
      if (r_state == S_RUN) r_x_prev <= r_x_cur;
    end else if (w_xfer) begin
      if (!w_last) begin
        r_acc <= w_acc_step;
        r_y   <= f_beat(w_acc_step);
        r_k   <= r_k + K_W'(1);
      end else begin
        r_x_prev <= r_x_cur;
      end
    end
  end

endmodule

// File: tb/tb_lpf_interp.sv
// Self-checking bench for lpf_interp (DATA_W=16, N=4): directed ramps plus a
// scoreboard fed by a closed-form model of every beat.
module tb_lpf_interp;

  localparam int DATA_W = 16;
  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] y_out;

  int n_checks = 0;
  int n_errors = 0;

  int  exp_q[$];
  int  m_prev = 0;
  bit  rnd_en = 0;
  bit  or_fixed = 1;
  bit  stall_prev = 0;
  int  stall_y = 0;

  lpf_interp #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: beat k of a ramp from p to x is floor((p*N + k*(x-p))/N).
  function automatic void model_push(input int x);
    for (int k = 1; k <= N; k++)
      exp_q.push_back(fdiv(m_prev * N + k * (x - m_prev), N));
    m_prev = x;
  endfunction

  // out_ready driver: fixed level or 50% random, changed just after each edge.
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_en ? 1'($urandom_range(0, 1)) : or_fixed;
    end
  end

  // Scoreboard and stall monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_hold", int'(y_out), stall_y);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", int'(y_out), 99999);
        else chk("beat", int'(y_out), exp_q.pop_front());
      end
      if (in_valid && in_ready) model_push(int'(x_in));
      stall_prev = out_valid && !out_ready;
      stall_y    = int'(y_out);
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    exp_q.delete();
    m_prev = 0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_y_out", int'(y_out), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic send(input int x, input bit hold);
    int n;
    n = 0;
    in_valid = 1;
    x_in     = DATA_W'(x);
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ramp4(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_valid"}, int'(out_valid), 1);
      chk({tag, "_y"}, int'(y_out), e[i]);
      step();
    end
  endtask

  initial begin
    int n;
    logic signed [DATA_W-1:0] r;
    rst_n    = 0;
    in_valid = 0;
    x_in     = '0;
    #12;
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_y", int'(y_out), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1;
    step();

    // 1-3: basic ramps and floor rounding
    send(400, 0);
    ramp4("t1", 100, 200, 300, 400);
    chk("t1_idle", int'(out_valid), 0);
    send(0, 0);
    ramp4("t2", 300, 200, 100, 0);
    chk("t2_idle", int'(out_valid), 0);
    send(-3, 0);
    ramp4("t3", -1, -2, -3, -3);
    chk("t3_idle", int'(out_valid), 0);

    // 4: back-to-back samples, no bubble, in_ready only on the last beat
    do_reset();
    step();
    in_valid = 1;
    x_in     = 16'sd400;
    step();
    x_in = 16'sd800;
    for (int i = 0; i < 8; i++) begin
      chk("t4_valid", int'(out_valid), 1);
      chk("t4_y", int'(y_out), 100 * (i + 1));
      chk("t4_in_ready", int'(in_ready), int'(i == 3 || i == 7));
      step();
      if (i == 3) in_valid = 0;
    end
    chk("t4_idle", int'(out_valid), 0);

    // 5: random back-pressure with random samples
    rnd_en = 1;
    for (int s = 0; s < 10; s++) begin
      r = DATA_W'($urandom);
      send(int'(r), 0);
    end
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      step();
      n++;
    end
    chk("t5_drained", exp_q.size(), 0);
    rnd_en = 0;
    step();
    step();
    chk("t5_idle", int'(out_valid), 0);

    // 6: full-scale extremes, reset mid-ramp, restart from zero
    do_reset();
    step();
    send(-32768, 0);
    ramp4("t6a", -8192, -16384, -24576, -32768);
    send(32767, 0);
    chk("t6b_y1", int'(y_out), -16385);
    step();
    chk("t6b_y2", int'(y_out), -1);
    step();
    rst_n = 0;
    #1;
    exp_q.delete();
    m_prev = 0;
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_y", int'(y_out), 0);
    step();
    rst_n = 1;
    step();
    send(4, 0);
    ramp4("t6c", 1, 2, 3, 4);
    chk("t6_idle", int'(out_valid), 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
